// File: rtl/axi_portal_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_portal_master
// Description : Single-outstanding AXI initiator for portal register access.
//               Turns cmd/wd pipes into AR/AW/W bursts and returns R/B on rsp.
//               Optional watchdog: define AXI_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_portal_master #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 6,
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  nRST,
    // command / write-data / response pipes
    input  logic                  cmd__ENA,
    output logic                  cmd__RDY,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wd__ENA,
    output logic                  wd__RDY,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic                  rsp__ENA,
    input  logic                  rsp__RDY,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    // AXI read address
    output logic                  AR__ENA,
    input  logic                  AR__RDY,
    output logic [ADDR_WIDTH-1:0] AR_addr,
    output logic [ID_WIDTH-1:0]   AR_id,
    output logic [LEN_WIDTH-1:0]  AR_len,
    // AXI write address
    output logic                  AW__ENA,
    input  logic                  AW__RDY,
    output logic [ADDR_WIDTH-1:0] AW_addr,
    output logic [ID_WIDTH-1:0]   AW_id,
    output logic [LEN_WIDTH-1:0]  AW_len,
    // AXI write data
    output logic                  W__ENA,
    input  logic                  W__RDY,
    output logic [DATA_WIDTH-1:0] W_data,
    output logic [ID_WIDTH-1:0]   W_id,
    output logic                  W_last,
    // AXI read data
    input  logic                  R__ENA,
    output logic                  R__RDY,
    input  logic [DATA_WIDTH-1:0] R_data,
    input  logic [ID_WIDTH-1:0]   R_id,
    input  logic                  R_last,
    input  logic [1:0]            R_resp,
    // AXI write response
    input  logic                  B__ENA,
    output logic                  B__RDY,
    input  logic [ID_WIDTH-1:0]   B_id,
    input  logic [1:0]            B_resp
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WADDR = 3'd3,
        S_WDATA = 3'd4,
        S_WRESP = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [ID_WIDTH-1:0]   tag_q, tag_d;
    logic [ID_WIDTH-1:0]   id_cnt_q, id_cnt_d;
    logic                  cmd_rdy_q, cmd_rdy_d;
    logic                  last_beat;
    logic                  tmo_fire;

    assign last_beat = (beat_q == len_q);

    // Address channel payloads come only from registers: no cmd->AXI path.
    assign AR_addr  = addr_q;
    assign AR_id    = tag_q;
    assign AR_len   = len_q;
    assign AW_addr  = addr_q;
    assign AW_id    = tag_q;
    assign AW_len   = len_q;
    assign W_data   = wd_data;
    assign W_id     = tag_q;
    assign W_last   = last_beat;
    assign cmd__RDY = cmd_rdy_q;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_fire = (tmo_q == TMO_W'(TIMEOUT));

    // Restart the watchdog on any progress; saturate once it has fired.
    always_comb begin
        tmo_d = tmo_q;
        if ((state_q == S_IDLE) || (state_d != state_q) || (beat_d != beat_q)) begin
            tmo_d = '0;
        end else if (!tmo_fire) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        tag_d    = tag_q;
        id_cnt_d = id_cnt_q;
        AR__ENA  = 1'b0;
        AW__ENA  = 1'b0;
        W__ENA   = 1'b0;
        wd__RDY  = 1'b0;
        R__RDY   = 1'b0;
        B__RDY   = 1'b0;
        rsp__ENA = 1'b0;
        rsp_data = '0;
        rsp_last = 1'b0;
        rsp_err  = 1'b0;

        if (tmo_fire) begin
            rsp__ENA = 1'b1;
            rsp_last = 1'b1;
            rsp_err  = 1'b1;
            if (rsp__RDY) begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd__ENA && cmd_rdy_q) begin
                        addr_d   = cmd_addr;
                        len_d    = cmd_len;
                        tag_d    = id_cnt_q;
                        id_cnt_d = id_cnt_q + 1'b1;
                        beat_d   = '0;
                        state_d  = cmd_write ? S_WADDR : S_RADDR;
                    end
                end
                S_RADDR: begin
                    AR__ENA = 1'b1;
                    if (AR__RDY) state_d = S_RDATA;
                end
                S_RDATA: begin
                    R__RDY   = rsp__RDY;
                    rsp__ENA = R__ENA;
                    rsp_data = R_data;
                    rsp_last = last_beat;
                    rsp_err  = (R_resp != 2'b00) || (R_id != tag_q) || (R_last != last_beat);
                    // Beat count, not R_last, decides the end of the burst.
                    if (R__ENA && rsp__RDY) begin
                        if (last_beat) begin
                            state_d = S_IDLE;
                            beat_d  = '0;
                        end else begin
                            beat_d  = beat_q + 1'b1;
                        end
                    end
                end
                S_WADDR: begin
                    AW__ENA = 1'b1;
                    if (AW__RDY) state_d = S_WDATA;
                end
                S_WDATA: begin
                    W__ENA  = wd__ENA;
                    wd__RDY = W__RDY;
                    if (wd__ENA && W__RDY) begin
                        if (last_beat) begin
                            state_d = S_WRESP;
                            beat_d  = '0;
                        end else begin
                            beat_d  = beat_q + 1'b1;
                        end
                    end
                end
                S_WRESP: begin
                    B__RDY   = rsp__RDY;
                    rsp__ENA = B__ENA;
                    rsp_last = 1'b1;
                    rsp_err  = (B_resp != 2'b00) || (B_id != tag_q);
                    if (B__ENA && rsp__RDY) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end
            endcase
        end

        // Ready is registered, so it appears one cycle after reset release.
        cmd_rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            tag_q     <= '0;
            id_cnt_q  <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            tag_q     <= tag_d;
            id_cnt_q  <= id_cnt_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_portal_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_portal_master
// Description : Directed self-checking bench for axi_portal_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_portal_master;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        cmd__ENA = 1'b0, cmd__RDY, cmd_write = 1'b0;
    logic [12:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        wd__ENA = 1'b0, wd__RDY;
    logic [31:0] wd_data = '0;
    logic        rsp__ENA, rsp__RDY = 1'b0, rsp_last, rsp_err;
    logic [31:0] rsp_data;
    logic        AR__ENA, AR__RDY = 1'b0;
    logic [12:0] AR_addr;
    logic [5:0]  AR_id;
    logic [3:0]  AR_len;
    logic        AW__ENA, AW__RDY = 1'b0;
    logic [12:0] AW_addr;
    logic [5:0]  AW_id;
    logic [3:0]  AW_len;
    logic        W__ENA, W__RDY = 1'b0, W_last;
    logic [31:0] W_data;
    logic [5:0]  W_id;
    logic        R__ENA = 1'b0, R__RDY, R_last = 1'b0;
    logic [31:0] R_data = '0;
    logic [5:0]  R_id = '0;
    logic [1:0]  R_resp = '0;
    logic        B__ENA = 1'b0, B__RDY;
    logic [5:0]  B_id = '0;
    logic [1:0]  B_resp = '0;

    int          checks = 0;
    int          failures = 0;
    logic [5:0]  exp_id = '0;
    logic [5:0]  cur_tag = '0;
    wire  [7:0]  outs = {cmd__RDY, AR__ENA, AW__ENA, W__ENA, wd__RDY, R__RDY, B__RDY, rsp__ENA};

    always #5 CLK = ~CLK;

    axi_portal_master #(.TIMEOUT(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .cmd__ENA(cmd__ENA), .cmd__RDY(cmd__RDY), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd__ENA(wd__ENA), .wd__RDY(wd__RDY), .wd_data(wd_data),
        .rsp__ENA(rsp__ENA), .rsp__RDY(rsp__RDY), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .AR__ENA(AR__ENA), .AR__RDY(AR__RDY), .AR_addr(AR_addr), .AR_id(AR_id), .AR_len(AR_len),
        .AW__ENA(AW__ENA), .AW__RDY(AW__RDY), .AW_addr(AW_addr), .AW_id(AW_id), .AW_len(AW_len),
        .W__ENA(W__ENA), .W__RDY(W__RDY), .W_data(W_data), .W_id(W_id), .W_last(W_last),
        .R__ENA(R__ENA), .R__RDY(R__RDY), .R_data(R_data), .R_id(R_id),
        .R_last(R_last), .R_resp(R_resp),
        .B__ENA(B__ENA), .B__RDY(B__RDY), .B_id(B_id), .B_resp(B_resp)
    );

    // Accept a command, then hold the address channel off for one cycle before accepting it.
    task automatic issue(input logic wr, input logic [12:0] addr, input logic [3:0] len);
        int n;
        n = 0;
        while (!cmd__RDY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (cmd__RDY !== 1'b1) begin
            failures++;
            $display("FAIL cmd_rdy_wait: cmd__RDY=%b required 1", cmd__RDY);
        end
        cmd__ENA = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        @(negedge CLK);
        cmd__ENA = 1'b0;
        cur_tag = exp_id;
        exp_id  = exp_id + 6'd1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (wr) begin
                if ({cmd__RDY, AR__ENA, AW__ENA, AW_addr, AW_id, AW_len} !==
                    {1'b0, 1'b0, 1'b1, addr, cur_tag, len}) begin
                    failures++;
                    $display("FAIL aw_payload: ena=%b addr=%h id=%h len=%h required 1 %h %h %h",
                             AW__ENA, AW_addr, AW_id, AW_len, addr, cur_tag, len);
                end
            end else begin
                if ({cmd__RDY, AW__ENA, AR__ENA, AR_addr, AR_id, AR_len} !==
                    {1'b0, 1'b0, 1'b1, addr, cur_tag, len}) begin
                    failures++;
                    $display("FAIL ar_payload: ena=%b addr=%h id=%h len=%h required 1 %h %h %h",
                             AR__ENA, AR_addr, AR_id, AR_len, addr, cur_tag, len);
                end
            end
            if (s == 0) @(negedge CLK);
        end
        if (wr) AW__RDY = 1'b1; else AR__RDY = 1'b1;
        @(negedge CLK);
        AW__RDY = 1'b0; AR__RDY = 1'b0;
        checks++;
        if ({AR__ENA, AW__ENA} !== 2'b00) begin
            failures++;
            $display("FAIL addr_drop: AR__ENA=%b AW__ENA=%b required 0 0", AR__ENA, AW__ENA);
        end
    endtask

    task automatic read_single(input logic [12:0] addr, input logic [31:0] data, input logic bad_id,
                               input logic rlast, input logic [1:0] resp, input logic exp_err);
        issue(1'b0, addr, 4'd0);
        R__ENA = 1'b1; R_data = data; R_id = bad_id ? 6'd5 : cur_tag;
        R_last = rlast; R_resp = resp; rsp__RDY = 1'b1;
        #1;
        checks++;
        if ({R__RDY, rsp__ENA, rsp_data, rsp_last, rsp_err} !== {1'b1, 1'b1, data, 1'b1, exp_err}) begin
            failures++;
            $display("FAIL rd_rsp: rdy=%b ena=%b data=%h last=%b err=%b required 1 1 %h 1 %b",
                     R__RDY, rsp__ENA, rsp_data, rsp_last, rsp_err, data, exp_err);
        end
        @(negedge CLK);
        R__ENA = 1'b0; rsp__RDY = 1'b0;
        checks++;
        if (cmd__RDY !== 1'b1) begin
            failures++;
            $display("FAIL rd_idle: cmd__RDY=%b required 1", cmd__RDY);
        end
    endtask

    task automatic write_single(input logic [12:0] addr, input logic [31:0] data, input logic bad_id,
                                input logic [1:0] resp, input logic exp_err);
        issue(1'b1, addr, 4'd0);
        wd__ENA = 1'b1; wd_data = data; W__RDY = 1'b1;
        #1;
        checks++;
        if ({W__ENA, wd__RDY, W_data, W_id, W_last} !== {1'b1, 1'b1, data, cur_tag, 1'b1}) begin
            failures++;
            $display("FAIL wr_beat: ena=%b rdy=%b data=%h id=%h last=%b required 1 1 %h %h 1",
                     W__ENA, wd__RDY, W_data, W_id, W_last, data, cur_tag);
        end
        @(negedge CLK);
        wd__ENA = 1'b0; W__RDY = 1'b0;
        B__ENA = 1'b1; B_id = bad_id ? cur_tag + 6'd1 : cur_tag; B_resp = resp; rsp__RDY = 1'b0;
        #1;
        checks++;
        if ({B__RDY, W__ENA} !== 2'b00) begin
            failures++;
            $display("FAIL wr_b_stall: B__RDY=%b W__ENA=%b required 0 0", B__RDY, W__ENA);
        end
        @(negedge CLK);
        rsp__RDY = 1'b1;
        #1;
        checks++;
        if ({B__RDY, rsp__ENA, rsp_data, rsp_last, rsp_err} !== {1'b1, 1'b1, 32'h0, 1'b1, exp_err}) begin
            failures++;
            $display("FAIL wr_rsp: rdy=%b ena=%b data=%h last=%b err=%b required 1 1 0 1 %b",
                     B__RDY, rsp__ENA, rsp_data, rsp_last, rsp_err, exp_err);
        end
        @(negedge CLK);
        B__ENA = 1'b0; rsp__RDY = 1'b0;
        checks++;
        if (cmd__RDY !== 1'b1) begin
            failures++;
            $display("FAIL wr_idle: cmd__RDY=%b required 1", cmd__RDY);
        end
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        R__ENA = 1'b1; B__ENA = 1'b1; rsp__RDY = 1'b1; wd__ENA = 1'b1; W__RDY = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL reset_outs: outs=%b required 00000000", outs);
        end
        wd__ENA = 1'b0; W__RDY = 1'b0;
        nRST = 1'b1;
        exp_id = '0;
        @(negedge CLK);
        checks++;
        if (cmd__RDY !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_rdy: cmd__RDY=%b required 1", cmd__RDY);
        end
        checks++;
        if ({R__RDY, B__RDY, rsp__ENA} !== 3'b000) begin
            failures++;
            $display("FAIL idle_holdoff: R__RDY=%b B__RDY=%b rsp__ENA=%b required 0 0 0",
                     R__RDY, B__RDY, rsp__ENA);
        end
        R__ENA = 1'b0; B__ENA = 1'b0; rsp__RDY = 1'b0;
    endtask

    task automatic test_read_single;
        read_single(13'h008, 32'h0000_0001, 1'b0, 1'b1, 2'b00, 1'b0);
    endtask

    task automatic test_write_single;
        write_single(13'h004, 32'h0000_0001, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic test_read_burst;
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        issue(1'b0, 13'h020, 4'd3);
        while (k < 4 && cyc < 20) begin
            rsp__RDY = (cyc % 2 == 0);
            R__ENA = 1'b1; R_data = 32'hA0 + k; R_id = cur_tag; R_last = (k == 3); R_resp = 2'b00;
            #1;
            if (rsp__RDY) begin
                checks++;
                if ({R__RDY, rsp__ENA, rsp_data, rsp_last, rsp_err} !==
                    {1'b1, 1'b1, 32'hA0 + k, (k == 3), 1'b0}) begin
                    failures++;
                    $display("FAIL burst_beat%0d: rdy=%b ena=%b data=%h last=%b err=%b required 1 1 %h %b 0",
                             k, R__RDY, rsp__ENA, rsp_data, rsp_last, rsp_err, 32'hA0 + k, (k == 3));
                end
                k++;
            end else begin
                checks++;
                if (R__RDY !== 1'b0) begin
                    failures++;
                    $display("FAIL burst_stall: R__RDY=%b required 0", R__RDY);
                end
            end
            @(negedge CLK);
            cyc++;
        end
        R__ENA = 1'b0; rsp__RDY = 1'b0;
        checks++;
        if (k !== 4 || cmd__RDY !== 1'b1) begin
            failures++;
            $display("FAIL burst_done: beats=%0d cmd__RDY=%b required 4 1", k, cmd__RDY);
        end
    endtask

    task automatic test_errors;
        read_single(13'h008, 32'h0000_0055, 1'b1, 1'b1, 2'b00, 1'b1);
        write_single(13'h004, 32'h0000_0002, 1'b0, 2'b10, 1'b1);
        read_single(13'h00C, 32'h0000_0066, 1'b0, 1'b0, 2'b00, 1'b1);
        write_single(13'h1004, 32'h0000_0003, 1'b1, 2'b00, 1'b1);
    endtask

    task automatic test_write_max;
        issue(1'b1, 13'h1000, 4'hF);
        W__RDY = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wd__ENA = 1'b1; wd_data = 32'h100 + k;
            #1;
            checks++;
            if ({W__ENA, W_last, W_data} !== {1'b1, (k == 15), 32'h100 + k}) begin
                failures++;
                $display("FAIL wmax_beat%0d: ena=%b last=%b data=%h required 1 %b %h",
                         k, W__ENA, W_last, W_data, (k == 15), 32'h100 + k);
            end
            @(negedge CLK);
        end
        wd__ENA = 1'b0; W__RDY = 1'b0;
        B__ENA = 1'b1; B_id = cur_tag; B_resp = 2'b00; rsp__RDY = 1'b1;
        #1;
        checks++;
        if ({W__ENA, rsp__ENA, rsp_last, rsp_err} !== 4'b0110) begin
            failures++;
            $display("FAIL wmax_rsp: W__ENA=%b ena=%b last=%b err=%b required 0 1 1 0",
                     W__ENA, rsp__ENA, rsp_last, rsp_err);
        end
        @(negedge CLK);
        B__ENA = 1'b0; rsp__RDY = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        issue(1'b1, 13'h010, 4'd3);
        wd__ENA = 1'b1; W__RDY = 1'b1; wd_data = 32'h11;
        #1;
        checks++;
        if ({W__ENA, W_last} !== 2'b10) begin
            failures++;
            $display("FAIL mid_beat0: ena=%b last=%b required 1 0", W__ENA, W_last);
        end
        @(negedge CLK);
        wd_data = 32'h22;
        #1;
        nRST = 1'b0;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_outs: outs=%b required 00000000", outs);
        end
        @(negedge CLK);
        wd__ENA = 1'b0; W__RDY = 1'b0;
        nRST = 1'b1;
        exp_id = '0;
        read_single(13'h008, 32'h0000_0077, 1'b0, 1'b1, 2'b00, 1'b0);
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        issue(1'b1, 13'h004, 4'd0);
        wd__ENA = 1'b1; W__RDY = 1'b1; wd_data = 32'h9;
        @(negedge CLK);
        wd__ENA = 1'b0; W__RDY = 1'b0; rsp__RDY = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            #1;
            checks++;
            if (rsp__ENA !== (c == 16)) begin
                failures++;
                $display("FAIL tmo_cycle%0d: rsp__ENA=%b required %b", c, rsp__ENA, (c == 16));
            end
            if (c < 16) @(negedge CLK);
        end
        checks++;
        if ({rsp_data, rsp_last, rsp_err} !== {32'h0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL tmo_rsp: data=%h last=%b err=%b required 0 1 1", rsp_data, rsp_last, rsp_err);
        end
        @(negedge CLK);
        B__ENA = 1'b1; B_id = cur_tag;
        #1;
        checks++;
        if ({cmd__RDY, B__RDY, rsp__ENA} !== 3'b100) begin
            failures++;
            $display("FAIL tmo_late_b: cmd__RDY=%b B__RDY=%b rsp__ENA=%b required 1 0 0",
                     cmd__RDY, B__RDY, rsp__ENA);
        end
        @(negedge CLK);
        B__ENA = 1'b0; rsp__RDY = 1'b0;
    endtask
`endif

    initial begin
        @(negedge CLK);
        test_reset();
        test_read_single();
        test_write_single();
        test_read_burst();
        test_errors();
        test_write_max();
        test_reset_mid_write();
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
